// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a word-wide memory bus.
// It holds one request at a time, aligns store lanes and extends load data.
module mem_access_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic        o_bus_write,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wmask,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  lane_off;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic        accept;
  logic        req_fault;
  logic [31:0] size_mask;
  logic [4:0]  req_shift;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  // Request decode: alignment fault, lane mask and lane shift.
  always_comb begin
    accept    = i_req_valid && o_req_ready && (state == IDLE);
    req_shift = {i_req_addr[1:0], 3'b000};
    req_fault = 1'b0;
    size_mask = 32'h0000_0000;
    case (i_req_size)
      2'd0: size_mask = 32'h0000_00FF;
      2'd1: begin
        size_mask = 32'h0000_FFFF;
        req_fault = i_req_addr[0];
      end
      2'd2: begin
        size_mask = 32'hFFFF_FFFF;
        req_fault = (i_req_addr[1:0] != 2'b00);
      end
      default: req_fault = 1'b1;
    endcase
  end

  // Returned word is moved down to bit 0, then truncated and extended.
  always_comb begin
    rd_shifted = i_bus_rdata >> {lane_off, 3'b000};
    case (acc_size)
      2'd0:    load_data = {{24{~acc_unsigned & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_data = {{16{~acc_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = req_fault ? RESP : ISSUE;
      ISSUE:   if (i_bus_ready) next_state = o_bus_write ? RESP : WAIT;
      WAIT:    if (i_bus_rvalid) next_state = RESP;
      RESP:    if (i_rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Handshake outputs follow the next state so they are registered and
  // ready stays low through the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_req_ready  <= 1'b0;
      o_bus_valid  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_fault  <= 1'b0;
      o_rsp_rdata  <= 32'h0;
      o_bus_write  <= 1'b0;
      o_bus_addr   <= 32'h0;
      o_bus_wmask  <= 32'h0;
      o_bus_wdata  <= 32'h0;
      lane_off     <= 2'b00;
      acc_size     <= 2'b00;
      acc_unsigned <= 1'b0;
    end else begin
      o_req_ready <= (next_state == IDLE);
      o_bus_valid <= (next_state == ISSUE);
      o_rsp_valid <= (next_state == RESP);
      if (accept) begin
        lane_off     <= i_req_addr[1:0];
        acc_size     <= i_req_size;
        acc_unsigned <= i_req_unsigned;
        o_rsp_fault  <= req_fault;
        o_rsp_rdata  <= 32'h0;
        if (!req_fault) begin
          o_bus_write <= i_req_write;
          o_bus_addr  <= {i_req_addr[31:2], 2'b00};
          o_bus_wmask <= size_mask << req_shift;
          o_bus_wdata <= (i_req_wdata & size_mask) << req_shift;
        end
      end
      if ((state == WAIT) && i_bus_rvalid) o_rsp_rdata <= load_data;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Module SHALL have no parameters; the data bus is fixed at 32 bits.
REQ-002 i_clk  input  1  sole clock, rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_req_valid / o_req_ready  in/out  1/1  pipeline request handshake.
REQ-005 i_req_write  input  1  1=store, 0=load.
REQ-006 i_req_addr  input  32  byte address.
REQ-007 i_req_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 i_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 i_req_wdata  input  32  store data, right-justified.
REQ-010 o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake.
REQ-011 o_rsp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-012 o_rsp_fault  output  1  misaligned or illegal-size request.
REQ-013 o_bus_valid / i_bus_ready  out/in  1/1  bus command handshake.
REQ-014 o_bus_write  output  1  command is a write.
REQ-015 o_bus_addr  output  32  word-aligned address (i_req_addr with bits [1:0] cleared).
REQ-016 o_bus_wmask  output  32  bit-granular lane mask.
REQ-017 o_bus_wdata  output  32  lane-shifted store data.
REQ-018 i_bus_rvalid / i_bus_rdata  input  1/32  read return; no backpressure.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP. All outputs SHALL be registered.
REQ-020 o_req_ready SHALL be 1 only in IDLE, and 0 during reset and on the first edge after reset release.
REQ-021 On an accept (valid&ready) in IDLE, the block SHALL latch all request fields.
  - No fault: next state is ISSUE.
  - Fault: next state is RESP; no bus command is issued.
REQ-022 Fault conditions: size 3; half with addr[0]=1; word with addr[1:0]!=0. Byte accesses never fault.
REQ-023 o_bus_wmask SHALL equal the size mask shifted left by 8*addr[1:0].
  - Size masks: 0x000000FF, 0x0000FFFF, 0xFFFFFFFF.
REQ-024 o_bus_wdata SHALL equal i_req_wdata, masked to the access size, shifted left by 8*addr[1:0]. Unmasked lanes are 0.
REQ-025 o_bus_valid SHALL be 1 throughout ISSUE.
  - Address, mask, data and write SHALL remain stable until i_bus_ready is sampled 1.
REQ-026 ISSUE exit on i_bus_ready=1: store goes to RESP; load goes to WAIT.
REQ-027 i_bus_rvalid SHALL be sampled only in WAIT and ignored in all other states.
REQ-028 In WAIT with i_bus_rvalid=1, the block SHALL capture i_bus_rdata, then go to RESP.
  - Captured data is shifted right by 8*addr[1:0].
  - It is truncated to the access size, then sign- or zero-extended per i_req_unsigned.
REQ-029 o_rsp_valid SHALL be 1 throughout RESP. o_rsp_rdata and o_rsp_fault SHALL be held stable until i_rsp_ready=1, after which the state is IDLE.
REQ-030 Latency from an accept at edge N, with zero-wait bus and sink:
  - o_bus_valid is high after edge N.
  - Store: o_rsp_valid high after edge N+1.
  - Load with rvalid in the first WAIT cycle: o_rsp_valid high after edge N+2.
  - Fault: o_rsp_valid high after edge N.
REQ-031 The block SHALL hold at most one outstanding request. No new request is accepted before the response handshake completes.

Reset
REQ-032 While i_rst_n=0:
  - State SHALL be IDLE.
  - o_req_ready, o_rsp_valid, o_rsp_fault, o_bus_valid and o_bus_write SHALL be 0.
  - o_bus_addr, o_bus_wmask, o_bus_wdata and o_rsp_rdata SHALL be 0.
REQ-033 Reset asserted in any state SHALL abort the transaction with no response. A later i_bus_rvalid from the aborted load SHALL be ignored.

Verification
REQ-034 Byte store: addr=0x1003, size=0, wdata=0x000000AB -> o_bus_addr=0x1000, wmask=0xFF000000, wdata=0xAB000000, write=1; rsp fault=0, rdata=0.
REQ-035 Signed half load: addr=0x2002, size=1, unsigned=0, rdata=0x8001_1234 -> o_rsp_rdata=0xFFFF8001. Same with unsigned=1 -> 0x00008001.
REQ-036 Misaligned word: addr=0x3001, size=2 -> o_bus_valid never asserts; o_rsp_fault=1, rdata=0 one cycle after the accept. Repeat with size=3 for the same result.
REQ-037 Backpressure: i_bus_ready low 3 cycles, then i_rsp_ready low 2 cycles -> bus and rsp outputs stable throughout; o_req_ready=0 until the rsp handshake.
REQ-038 Reset asserted in WAIT, then i_bus_rvalid=1 after release -> no o_rsp_valid; next request handled normally.
